// File: rtl/psum_out_stage.sv
// Output stage of the row-streamed convolution: drops incomplete/edge-wrapping windows,
// then rounds, shifts and saturates each partial sum. Build option PSUM_OUT_RELU_EN clamps negatives to 0.
module psum_out_stage #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned KER    = 3,
  parameter int unsigned SUM_BW = 16,
  parameter int unsigned OUT_BW = 8,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic signed [SUM_BW-1:0] i_psum,
  output logic                     o_valid,
  output logic signed [OUT_BW-1:0] o_data,
  output logic                     o_last,
  output logic                     o_busy
);

  localparam int unsigned CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SW1 = SUM_BW + 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_OUT = CW'(KER - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(KER - 1);

  localparam logic signed [SW1-1:0] RND   = SW1'((1 << SHIFT) >> 1);
  localparam logic signed [SW1-1:0] MAX_V = {{(SW1-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [SW1-1:0] MIN_V = {{(SW1-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col, col_nxt, pos_col;
  logic [RW-1:0]   row, row_nxt, pos_row;
  logic            accept_c, emit_c, last_c;

  logic                  s1_valid, s1_last;
  logic signed [SW1-1:0] s1_r, psum_ext, r_c, r_clip;
  logic signed [OUT_BW-1:0] sat_c;

  // State and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      o_busy <= (state_nxt != IDLE);
    end
  end

  // Next state: an sof beat always restarts the frame at (0,0), even mid-frame
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    pos_col   = col;
    pos_row   = row;
    emit_c    = 1'b0;
    last_c    = 1'b0;
    accept_c  = i_valid && (i_sof || (state != IDLE));
    if (i_sof) begin
      pos_col = '0;
      pos_row = '0;
    end
    if (accept_c) begin
      emit_c = (pos_row >= ROW_FIRST_OUT) && (pos_col >= COL_FIRST_OUT);
      last_c = emit_c && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      if (pos_col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = pos_row + RW'(1);
      end else begin
        col_nxt = pos_col + CW'(1);
        row_nxt = pos_row;
      end
      if (last_c) begin
        state_nxt = IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
      end else if (row_nxt >= ROW_FIRST_OUT) begin
        state_nxt = RUN;
      end else begin
        state_nxt = FILL;
      end
    end
  end

  // One extra bit keeps the rounding add from overflowing
  assign psum_ext = {i_psum[SUM_BW-1], i_psum};
  assign r_c      = (psum_ext + RND) >>> SHIFT;

  always_comb begin
    r_clip = s1_r;
    sat_c  = s1_r[OUT_BW-1:0];
`ifdef PSUM_OUT_RELU_EN
    if (s1_r[SW1-1]) r_clip = '0;
`endif
    if (r_clip > MAX_V)      sat_c = MAX_V[OUT_BW-1:0];
    else if (r_clip < MIN_V) sat_c = MIN_V[OUT_BW-1:0];
    else                     sat_c = r_clip[OUT_BW-1:0];
  end

  // Two-stage requantization pipeline; o_data holds between outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
    end else begin
      s1_valid <= emit_c;
      s1_last  <= last_c;
      if (emit_c) s1_r <= r_c;
      o_valid  <= s1_valid;
      o_last   <= s1_valid & s1_last;
      if (s1_valid) o_data <= sat_c;
    end
  end

endmodule

// File: tb/tb_psum_out_stage.sv
// Directed bench for psum_out_stage: frame model pushes expected outputs, a negedge monitor pops them.
module tb_psum_out_stage;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned K  = 3;
  localparam int unsigned SB = 16;
  localparam int unsigned OB = 8;
  localparam int unsigned SH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_valid;
  logic                 i_sof;
  logic signed [SB-1:0] i_psum;
  logic                 o_valid;
  logic signed [OB-1:0] o_data;
  logic                 o_last;
  logic                 o_busy;

  psum_out_stage #(
    .IMG_W(W), .IMG_H(H), .KER(K), .SUM_BW(SB), .OUT_BW(OB), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_psum(i_psum),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     data;
    bit     last;
    longint cyc;
    int     idx;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     n_out = 0;
  int     n_last = 0;
  int     m_idx = 0;
  bit     m_in = 1'b0;
  string  tag = "reset";
  int     psum_tab[int];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference requantization: floor((p + half) / 2^SH), then clamp
  function automatic int qref(input int p);
    int num, div, r;
    div = 1 << SH;
    num = p + (div >> 1);
    r = num / div;
    if (num < 0 && (num % div) != 0) r = r - 1;
`ifdef PSUM_OUT_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > (1 << (OB - 1)) - 1) r = (1 << (OB - 1)) - 1;
    if (r < -(1 << (OB - 1))) r = -(1 << (OB - 1));
    return r;
  endfunction

  // Drive one cycle; the frame model decides whether it yields an output
  task automatic beat(input bit v, input bit sof, input int psum);
    exp_t e;
    i_valid = v;
    i_sof   = sof;
    i_psum  = SB'(psum);
    if (v) begin
      if (sof) begin
        m_idx = 0;
        m_in  = 1'b1;
      end
      if (m_in) begin
        if ((m_idx / W) >= K - 1 && (m_idx % W) >= K - 1) begin
          e.data = qref(psum);
          e.last = (m_idx == W * H - 1);
          e.cyc  = cyc + 2;
          e.idx  = m_idx;
          q.push_back(e);
        end
        m_idx++;
        if (m_idx == W * H) m_in = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    checks++;
    assert (o_busy === m_in)
      else begin failures++; $error("FAIL %s busy got=%b exp=%b", tag, o_busy, m_in); end
  endtask

  task automatic frame(input int gap_pct, input bit use_tab);
    for (int i = 0; i < W * H; i++) begin
      while ($urandom_range(99) < gap_pct) beat(1'b0, 1'b0, 0);
      beat(1'b1, i == 0, (use_tab && psum_tab.exists(i)) ? psum_tab[i] : i * 16);
    end
  endtask

  task automatic drain_check(input int exp_out, input int exp_last);
    repeat (4) beat(1'b0, 1'b0, 0);
    checks++;
    assert (q.size() == 0)
      else begin failures++; $error("FAIL %s pending got=%0d exp=0", tag, q.size()); end
    checks++;
    assert (n_out == exp_out)
      else begin failures++; $error("FAIL %s n_out got=%0d exp=%0d", tag, n_out, exp_out); end
    checks++;
    assert (n_last == exp_last)
      else begin failures++; $error("FAIL %s n_last got=%0d exp=%0d", tag, n_last, exp_last); end
    n_out  = 0;
    n_last = 0;
  endtask

  task automatic check_zero_outputs();
    checks++;
    assert (o_valid === 1'b0 && o_last === 1'b0 && o_busy === 1'b0 && o_data === '0)
      else begin
        failures++;
        $error("FAIL %s reset_out got=%b/%b/%b/%0d exp=0/0/0/0", tag, o_valid, o_last, o_busy, o_data);
      end
  endtask

  // Monitor: every o_valid must match the head of the scoreboard, on its cycle
  always @(negedge clk) begin
    exp_t e;
    int   od;
    if (rst_n === 1'b1) begin
      if (o_valid === 1'b1) begin
        od = int'(o_data);
        n_out++;
        if (o_last === 1'b1) n_last++;
        checks++;
        assert (q.size() > 0)
          else begin failures++; $error("FAIL %s unexpected_out got=%0d exp=none", tag, od); end
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          assert (od === e.data)
            else begin failures++; $error("FAIL %s data idx=%0d got=%0d exp=%0d", tag, e.idx, od, e.data); end
          checks++;
          assert (o_last === e.last)
            else begin failures++; $error("FAIL %s last idx=%0d got=%b exp=%b", tag, e.idx, o_last, e.last); end
          checks++;
          assert (cyc === e.cyc)
            else begin failures++; $error("FAIL %s latency idx=%0d got=%0d exp=%0d", tag, e.idx, cyc, e.cyc); end
        end
      end else begin
        checks++;
        assert (o_last === 1'b0)
          else begin failures++; $error("FAIL %s last_without_valid got=%b exp=0", tag, o_last); end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_psum  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs();
    rst_n = 1'b1;
    beat(1'b0, 1'b0, 0);

    // Full frame followed back-to-back by the rounding/saturation frame
    tag = "full_and_round";
    psum_tab[12] = 8;
    psum_tab[13] = 7;
    psum_tab[14] = -8;
    psum_tab[17] = -9;
    psum_tab[18] = 32767;
    psum_tab[19] = -32768;
    frame(0, 1'b0);
    frame(0, 1'b1);
    drain_check(12, 2);

    tag = "gapped";
    frame(30, 1'b0);
    drain_check(6, 1);

    tag = "pre_sof";
    repeat (10) beat(1'b1, 1'b0, int'($urandom_range(1000)));
    frame(0, 1'b0);
    drain_check(6, 1);

    // sof re-issued at raster index 13 of frame A
    tag = "mid_sof";
    for (int i = 0; i <= 12; i++) beat(1'b1, i == 0, i * 16 + 3);
    frame(0, 1'b0);
    drain_check(7, 1);

    // Reset asserted where raster index 18 would have been driven
    tag = "mid_reset";
    for (int i = 0; i <= 17; i++) beat(1'b1, i == 0, i * 16);
    rst_n = 1'b0;
    q.delete();
    m_in  = 1'b0;
    m_idx = 0;
    #1;
    check_zero_outputs();
    @(posedge clk);
    #1;
    check_zero_outputs();
    rst_n = 1'b1;
    drain_check(3, 0);
    for (int i = 18; i < 24; i++) beat(1'b1, 1'b0, i * 16);
    drain_check(0, 0);
    frame(0, 1'b0);
    drain_check(6, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
